// File: rtl/imem_prefetch_buf_if.sv
// Bundle of core-facing fetch, redirect and instruction-memory signals for the
// prefetch buffer. The slave modport is the buffer; the master modport is its environment.
interface imem_prefetch_buf_if #(
  parameter int DEPTH = 4
);
  logic                     redirect_i;
  logic [31:0]              redirect_pc_i;
  logic                     fetch_valid_o;
  logic [31:0]              fetch_instr_o;
  logic [31:0]              fetch_pc_o;
  logic                     fetch_ready_i;
  logic                     mem_r_en_o;
  logic [31:0]              mem_addr_o;
  logic [31:0]              mem_rdata_i;
  logic [$clog2(DEPTH):0]   occupancy_o;

  modport slave (
    input  redirect_i,
    input  redirect_pc_i,
    input  fetch_ready_i,
    input  mem_rdata_i,
    output fetch_valid_o,
    output fetch_instr_o,
    output fetch_pc_o,
    output mem_r_en_o,
    output mem_addr_o,
    output occupancy_o
  );

  modport master (
    output redirect_i,
    output redirect_pc_i,
    output fetch_ready_i,
    output mem_rdata_i,
    input  fetch_valid_o,
    input  fetch_instr_o,
    input  fetch_pc_o,
    input  mem_r_en_o,
    input  mem_addr_o,
    input  occupancy_o
  );
endinterface

// File: rtl/imem_prefetch_buf.sv
// Instruction prefetch buffer: streams sequential fetches from a 1-cycle-latency
// memory into a small FIFO of {pc, instr}, flushing on redirect or reset.
module imem_prefetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  imem_prefetch_buf_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imem_prefetch_buf: DEPTH must be a power of two in 2..16");
  end

  typedef logic [AW-1:0] ptr_t;

  logic [31:0]   next_pc_q, next_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   fifo_q [DEPTH];

  logic          flush;
  logic [CW:0]   pending;
  logic          issue;
  logic          push;
  logic          valid;
  logic          pop;
  logic [63:0]   head;

  assign flush   = rst | bus.redirect_i;
  // Outstanding read counts against capacity so a return can never overflow.
  assign pending = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue   = !flush && (pending < DEPTH_L);
  assign push    = inflight_q && !flush;
  assign valid   = !flush && (count_q != '0);
  assign pop     = valid && bus.fetch_ready_i;
  assign head    = fifo_q[rd_ptr_q];

  assign bus.mem_r_en_o    = issue;
  assign bus.mem_addr_o    = rst ? RESET_PC : next_pc_q;
  assign bus.fetch_valid_o = valid;
  assign bus.fetch_pc_o    = head[63:32];
  assign bus.fetch_instr_o = head[31:0];
  assign bus.occupancy_o   = rst ? '0 : count_q;

  always_comb begin
    next_pc_d     = next_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (bus.redirect_i) begin
      next_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (issue) begin
        next_pc_d     = next_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = next_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: reset wins over redirect, which is already folded into _d.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      next_pc_q  <= next_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      fifo_q[wr_ptr_q] <= {inflight_pc_q, bus.mem_rdata_i};
    end
  end

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Bench for imem_prefetch_buf: directed timing scenarios plus random stalls/redirects,
// with a pc-stream scoreboard and a word-index memory model.
module tb_imem_prefetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_prefetch_buf_if #(.DEPTH(DEPTH)) bus();

  imem_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // memory[i] = i for word index i
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    bus.mem_rdata_i <= bus.mem_r_en_o ? word_at(bus.mem_addr_o) : 32'hDEAD_BEEF;
  end

  // Expected delivery stream: sequential pcs from the latest restart point.
  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    topup();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst || bus.redirect_i) begin
      chk("valid_during_flush", {31'b0, bus.fetch_valid_o}, 32'd0);
    end else if (bus.fetch_valid_o && bus.fetch_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual_pc=0x%08h required=no_delivery", bus.fetch_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.fetch_pc_o, e);
        chk("sb_instr", bus.fetch_instr_o, word_at(e));
        delivered++;
      end
    end
    checks++;
    if (bus.occupancy_o > DEPTH) begin
      failures++;
      $display("FAIL occ_bound actual=%0d required<=%0d", bus.occupancy_o, DEPTH);
    end
  end

  initial begin
    int          issues;
    int          d0;
    int          r;
    logic [31:0] t;

    // Cold start
    rst = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.fetch_ready_i = 1'b1;
    restart(RESET_PC);
    mid();
    chk("rst_ren", {31'b0, bus.mem_r_en_o}, 32'd0);
    chk("rst_valid", {31'b0, bus.fetch_valid_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, RESET_PC);
    chk("rst_occ", 32'(bus.occupancy_o), 32'd0);
    next();
    next();
    next();
    rst = 1'b0;
    mid();
    chk("cold_ren", {31'b0, bus.mem_r_en_o}, 32'd1);
    chk("cold_addr", bus.mem_addr_o, 32'h0);
    chk("cold_valid0", {31'b0, bus.fetch_valid_o}, 32'd0);
    next();
    mid();
    chk("cold_addr1", bus.mem_addr_o, 32'h4);
    chk("cold_valid1", {31'b0, bus.fetch_valid_o}, 32'd0);
    next();
    mid();
    chk("cold_valid2", {31'b0, bus.fetch_valid_o}, 32'd1);
    chk("cold_pc2", bus.fetch_pc_o, 32'h0);
    chk("cold_instr2", bus.fetch_instr_o, 32'h0);
    repeat (8) next();

    // Backpressure from reset
    rst = 1'b1;
    bus.fetch_ready_i = 1'b0;
    restart(RESET_PC);
    next();
    rst = 1'b0;
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (bus.mem_r_en_o) begin
        chk("bp_issue_addr", bus.mem_addr_o, 32'(issues * 4));
        issues++;
      end
      next();
    end
    chk("bp_issue_count", 32'(issues), 32'd4);
    mid();
    chk("bp_occ_full", 32'(bus.occupancy_o), 32'(DEPTH));
    chk("bp_ren_held", {31'b0, bus.mem_r_en_o}, 32'd0);
    next();
    bus.fetch_ready_i = 1'b1;
    mid();
    chk("bp_no_pop_credit", {31'b0, bus.mem_r_en_o}, 32'd0);
    next();
    mid();
    chk("bp_resume_ren", {31'b0, bus.mem_r_en_o}, 32'd1);
    chk("bp_resume_addr", bus.mem_addr_o, 32'h10);
    repeat (10) next();

    // Redirect with occupancy 3 and a read in flight
    rst = 1'b1;
    bus.fetch_ready_i = 1'b0;
    restart(RESET_PC);
    next();
    rst = 1'b0;
    repeat (4) next();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    restart(32'h0000_0100);
    mid();
    chk("rd_occ_before", 32'(bus.occupancy_o), 32'd3);
    chk("rd_ren_R", {31'b0, bus.mem_r_en_o}, 32'd0);
    next();
    bus.redirect_i    = 1'b0;
    bus.fetch_ready_i = 1'b1;
    mid();
    chk("rd_occ_R1", 32'(bus.occupancy_o), 32'd0);
    chk("rd_ren_R1", {31'b0, bus.mem_r_en_o}, 32'd1);
    chk("rd_addr_R1", bus.mem_addr_o, 32'h100);
    next();
    mid();
    chk("rd_valid_R2", {31'b0, bus.fetch_valid_o}, 32'd0);
    next();
    mid();
    chk("rd_valid_R3", {31'b0, bus.fetch_valid_o}, 32'd1);
    chk("rd_pc_R3", bus.fetch_pc_o, 32'h100);
    repeat (6) next();

    // Address wrap
    d0 = delivered;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    restart(32'hFFFF_FFF8);
    next();
    bus.redirect_i = 1'b0;
    repeat (8) next();
    chk("wrap_delivered", {31'b0, (delivered - d0) >= 4}, 32'd1);

    // Mid-run reset with a full FIFO
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    bus.fetch_ready_i = 1'b0;
    restart(32'h0000_0200);
    next();
    bus.redirect_i = 1'b0;
    repeat (8) next();
    mid();
    chk("mr_occ_full", 32'(bus.occupancy_o), 32'(DEPTH));
    next();
    rst = 1'b1;
    restart(RESET_PC);
    next();
    rst = 1'b0;
    bus.fetch_ready_i = 1'b1;
    mid();
    chk("mr_occ0", 32'(bus.occupancy_o), 32'd0);
    chk("mr_valid0", {31'b0, bus.fetch_valid_o}, 32'd0);
    chk("mr_ren", {31'b0, bus.mem_r_en_o}, 32'd1);
    chk("mr_addr", bus.mem_addr_o, RESET_PC);
    repeat (6) next();

    // Random stalls, redirects and occasional resets
    d0 = delivered;
    for (int i = 0; i < 10000; i++) begin
      next();
      rst = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 999);
      if (r < 2) begin
        rst = 1'b1;
        restart(RESET_PC);
      end else if (r < 20) begin
        t = $urandom;
        if (r < 6) t = 32'hFFFF_FFF0 | {28'h0, t[3:0]};
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = t;
        restart({t[31:2], 2'b00});
      end
    end
    next();
    rst = 1'b0;
    bus.redirect_i = 1'b0;
    mid();
    chk("rand_throughput", {31'b0, (delivered - d0) > 2000}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
